// File: rtl/croc_boot_seq_pkg.sv
// croc_boot_pkg: shared types and default parameters for the croc board boot
// sequencer.
//   boot_state_e : sequencer state encoding, also visible on state_o
//   Def*         : default timing parameters for a 20 MHz soc_clk
package croc_boot_pkg;

   localparam int unsigned StateW = 3;

   typedef enum logic [StateW-1:0] {
      WAIT_LOCK  = 3'd0,
      RST_HOLD   = 3'd1,
      WAIT_FETCH = 3'd2,
      RUN        = 3'd3,
      DONE       = 3'd4
   } boot_state_e;

   localparam int unsigned DefRstHoldCycles    = 1024;
   localparam int unsigned DefFetchDelayCycles = 256;
   // 1 ms at 20 MHz
   localparam int unsigned DefDebounceCycles   = 20000;
   localparam int unsigned DefCntWidth         = 16;

endpackage

// File: rtl/croc_boot_seq_if.sv
// croc_boot_seq_if: board/SoC-facing signals of the boot sequencer.
//   clk_locked_i   : clock wizard lock, asynchronous
//   sw_reset_req_i : level reset request, synchronous to soc_clk
//   fetch_sw_i     : raw fetch-enable switch, asynchronous
//   status_i       : SoC status
//   soc_rst_no     : active-low SoC reset
//   fetch_en_o     : SoC fetch enable
//   done_o         : sticky completion flag
//   state_o        : sequencer state for LEDs / ILA
// Signalling: there is no valid/ready handshake here. All inputs are levels
// sampled every soc_clk edge; all outputs are registered levels that change
// only on a soc_clk edge or on rst_n assertion.
interface croc_boot_seq_if;
   import croc_boot_pkg::*;

   logic              clk_locked_i;
   logic              sw_reset_req_i;
   logic              fetch_sw_i;
   logic              status_i;
   logic              soc_rst_no;
   logic              fetch_en_o;
   logic              done_o;
   logic [StateW-1:0] state_o;

   // sequencer side
   modport master (
      input  clk_locked_i, sw_reset_req_i, fetch_sw_i, status_i,
      output soc_rst_no, fetch_en_o, done_o, state_o
   );

   // board / SoC side
   modport slave (
      output clk_locked_i, sw_reset_req_i, fetch_sw_i, status_i,
      input  soc_rst_no, fetch_en_o, done_o, state_o
   );

endinterface

// File: rtl/croc_debounce.sv
// croc_debounce: 2-flop synchroniser followed by a stable-count debouncer.
//   soc_clk : clock
//   rst_n   : asynchronous active-low reset (output resets to 0)
//   sw_i    : raw asynchronous switch / button
//   sw_o    : debounced level; changes only after the synchronised input has
//             differed from it for DebounceCycles consecutive cycles
module croc_debounce #(
   parameter int unsigned DebounceCycles = 20000,
   parameter int unsigned CntWidth       = 16
) (
   input  logic soc_clk,
   input  logic rst_n,
   input  logic sw_i,
   output logic sw_o
);

   localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

   logic [1:0]          sync_q;
   logic [CntWidth-1:0] cnt_q;
   logic                out_q;

   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
         cnt_q  <= '0;
         out_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], sw_i};
         if (sync_q[1] != out_q) begin
            // the cycle that completes the run flips the output
            if (cnt_q == CntLast) begin
               out_q <= sync_q[1];
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            // any bounce back to the current value restarts the run
            cnt_q <= '0;
         end
      end
   end

   assign sw_o = out_q;

endmodule

// File: rtl/sync.sv
// sync: multi-stage flop synchroniser (common cells library cell).
//   clk_i    : destination clock
//   rst_ni   : asynchronous active-low reset
//   serial_i : asynchronous input
//   serial_o : synchronised output, STAGES cycles of latency
module sync #(
   parameter int unsigned STAGES     = 2,
   parameter bit          ResetValue = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic serial_i,
   output logic serial_o
);

   logic [STAGES-1:0] reg_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         reg_q <= {STAGES{ResetValue}};
      end else begin
         reg_q <= {reg_q[STAGES-2:0], serial_i};
      end
   end

   assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/croc_boot_seq.sv
// croc_boot_seq: board boot / reset sequencer for the croc SoC.
// Waits for clock lock, holds SoC reset for RstHoldCycles, releases it, waits
// FetchDelayCycles and then raises fetch enable once the debounced fetch
// switch is on. Latches SoC completion from status_i.
//   soc_clk : 20 MHz clock from the clock wizard
//   rst_n   : asynchronous active-low reset
//   bif     : board/SoC signals (see croc_boot_seq_if)
module croc_boot_seq
   import croc_boot_pkg::*;
#(
   parameter int unsigned RstHoldCycles    = DefRstHoldCycles,
   parameter int unsigned FetchDelayCycles = DefFetchDelayCycles,
   parameter int unsigned DebounceCycles   = DefDebounceCycles,
   parameter int unsigned CntWidth         = DefCntWidth
) (
   input  logic                   soc_clk,
   input  logic                   rst_n,
   croc_boot_seq_if.master        bif
);

   localparam logic [2:0] ST_WAIT_LOCK  = WAIT_LOCK;
   localparam logic [2:0] ST_RST_HOLD   = RST_HOLD;
   localparam logic [2:0] ST_WAIT_FETCH = WAIT_FETCH;
   localparam logic [2:0] ST_RUN        = RUN;
   localparam logic [2:0] ST_DONE       = DONE;

   localparam logic [CntWidth-1:0] HoldLast  = CntWidth'(RstHoldCycles - 1);
   localparam logic [CntWidth-1:0] DelayLast = CntWidth'(FetchDelayCycles - 1);

   logic                lock_s;
   logic                fetch_sw_deb;
   logic [2:0]          state_q, state_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                soc_rst_nq, fetch_en_q, done_q;

   sync #(
      .STAGES     (2),
      .ResetValue (1'b0)
   ) u_lock_sync (
      .clk_i    (soc_clk),
      .rst_ni   (rst_n),
      .serial_i (bif.clk_locked_i),
      .serial_o (lock_s)
   );

   croc_debounce #(
      .DebounceCycles (DebounceCycles),
      .CntWidth       (CntWidth)
   ) u_debounce (
      .soc_clk (soc_clk),
      .rst_n   (rst_n),
      .sw_i    (bif.fetch_sw_i),
      .sw_o    (fetch_sw_deb)
   );

   // Lock loss beats a reset request, which beats every per-state transition.
   // Every state entry clears the counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_WAIT_LOCK) begin
         if (lock_s) begin
            state_d = ST_RST_HOLD;
            cnt_d   = '0;
         end
      end else if (!lock_s) begin
         state_d = ST_WAIT_LOCK;
         cnt_d   = '0;
      end else if (bif.sw_reset_req_i) begin
         // re-entering RST_HOLD each cycle keeps the hold count at zero
         state_d = ST_RST_HOLD;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_RST_HOLD: begin
               if (cnt_q >= HoldLast) begin
                  state_d = ST_WAIT_FETCH;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_WAIT_FETCH: begin
               // status_i is deliberately ignored until fetch is enabled
               if (cnt_q >= DelayLast) begin
                  if (fetch_sw_deb) begin
                     state_d = ST_RUN;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (bif.status_i) begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they change on the same
   // edge as the state itself. Fetch enable stays high in RUN/DONE even if the
   // switch drops: the SoC samples it once and it is sticky until reset.
   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_WAIT_LOCK;
         cnt_q      <= '0;
         soc_rst_nq <= 1'b0;
         fetch_en_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         soc_rst_nq <= (state_d == ST_WAIT_FETCH) || (state_d == ST_RUN) ||
                       (state_d == ST_DONE);
         fetch_en_q <= (state_d == ST_RUN) || (state_d == ST_DONE);
         done_q     <= (state_d == ST_DONE);
      end
   end

   assign bif.soc_rst_no = soc_rst_nq;
   assign bif.fetch_en_o = fetch_en_q;
   assign bif.done_o     = done_q;
   assign bif.state_o    = state_q;

endmodule

// File: tb/tb_croc_boot_seq.sv
// tb_croc_boot_seq: directed timing scenarios plus randomized traffic for
// croc_boot_seq, checked every cycle against a timer-based reference model.
module tb_croc_boot_seq;
   import croc_boot_pkg::*;

   localparam int unsigned RH = 8;
   localparam int unsigned FD = 4;
   localparam int unsigned DB = 3;
   localparam int unsigned CW = 16;

   // ---------------- clock / reset ----------------
   logic soc_clk = 1'b0;
   logic rst_n   = 1'b0;

   always #25 soc_clk = ~soc_clk;

   croc_boot_seq_if bif ();

   croc_boot_seq #(
      .RstHoldCycles    (RH),
      .FetchDelayCycles (FD),
      .DebounceCycles   (DB),
      .CntWidth         (CW)
   ) dut (
      .soc_clk (soc_clk),
      .rst_n   (rst_n),
      .bif     (bif)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Timers count down the cycles still owed in the current phase; the
   // synchronisers are modelled as two-deep input histories.
   boot_state_e m_phase;
   int          hold_left, delay_left, run_len;
   bit          l1, l2, s1, s2, m_deb;

   function automatic void model_reset();
      m_phase    = WAIT_LOCK;
      hold_left  = 0;
      delay_left = 0;
      run_len    = 0;
      l1 = 0; l2 = 0; s1 = 0; s2 = 0; m_deb = 0;
   endfunction

   function automatic void enter_hold();
      m_phase   = RST_HOLD;
      hold_left = RH;
   endfunction

   task automatic model_step();
      bit lk, rq, sw, st, lock_seen, deb_seen;
      lk = bif.clk_locked_i; rq = bif.sw_reset_req_i;
      sw = bif.fetch_sw_i;   st = bif.status_i;
      lock_seen = l2;
      deb_seen  = m_deb;
      if (m_phase == WAIT_LOCK) begin
         if (lock_seen) enter_hold();
      end else if (!lock_seen) begin
         m_phase = WAIT_LOCK;
      end else if (rq) begin
         enter_hold();
      end else begin
         case (m_phase)
            RST_HOLD: begin
               hold_left--;
               if (hold_left == 0) begin
                  m_phase    = WAIT_FETCH;
                  delay_left = FD;
               end
            end
            WAIT_FETCH: begin
               if (delay_left > 0) delay_left--;
               if (delay_left == 0 && deb_seen) m_phase = RUN;
            end
            RUN:     if (st) m_phase = DONE;
            default: ;
         endcase
      end
      if (s2 != m_deb) begin
         run_len++;
         if (run_len == DB) begin
            m_deb   = s2;
            run_len = 0;
         end
      end else begin
         run_len = 0;
      end
      l2 = l1; l1 = lk;
      s2 = s1; s1 = sw;
   endtask

   task automatic compare_all();
      bit e_rst, e_fetch, e_done;
      e_rst   = (m_phase == WAIT_FETCH) || (m_phase == RUN) || (m_phase == DONE);
      e_fetch = (m_phase == RUN) || (m_phase == DONE);
      e_done  = (m_phase == DONE);
      check_eq("model_state_o",    32'(bif.state_o),    32'(m_phase));
      check_eq("model_soc_rst_no", 32'(bif.soc_rst_no), 32'(e_rst));
      check_eq("model_fetch_en_o", 32'(bif.fetch_en_o), 32'(e_fetch));
      check_eq("model_done_o",     32'(bif.done_o),     32'(e_done));
   endtask

   // ---------------- driver tasks ----------------
   // One clock edge: model consumes the inputs sampled at the edge, outputs
   // are compared on the following falling edge, then the caller may drive.
   task automatic tick();
      @(posedge soc_clk);
      model_step();
      @(negedge soc_clk);
      compare_all();
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_state_o"},    32'(bif.state_o),    32'(WAIT_LOCK));
      check_eq({tag, "_soc_rst_no"}, 32'(bif.soc_rst_no), 32'd0);
      check_eq({tag, "_fetch_en_o"}, 32'(bif.fetch_en_o), 32'd0);
      check_eq({tag, "_done_o"},     32'(bif.done_o),     32'd0);
      check_eq({tag, "_deb"},        32'(dut.u_debounce.sw_o), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge soc_clk);
      check_reset_values("reset");
      rst_n = 1'b1;
   endtask

   // Lock rises just after edge 0; expects state 1 at edge 3, reset release at
   // edge 11 and fetch enable at edge 15.
   task automatic power_up_seq(input string tag);
      tick();
      bif.clk_locked_i = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         tick();
         if (e == 2)  check_eq({tag, "_state_e2"},  32'(bif.state_o),    32'd0);
         if (e == 3)  check_eq({tag, "_state_e3"},  32'(bif.state_o),    32'd1);
         if (e == 10) check_eq({tag, "_rst_e10"},   32'(bif.soc_rst_no), 32'd0);
         if (e == 11) check_eq({tag, "_rst_e11"},   32'(bif.soc_rst_no), 32'd1);
         if (e == 14) check_eq({tag, "_fetch_e14"}, 32'(bif.fetch_en_o), 32'd0);
         if (e == 15) check_eq({tag, "_fetch_e15"}, 32'(bif.fetch_en_o), 32'd1);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] toggles;
      int         lock_off, req_left;

      bif.clk_locked_i   = 1'b0;
      bif.sw_reset_req_i = 1'b0;
      bif.fetch_sw_i     = 1'b1;
      bif.status_i       = 1'b0;
      do_reset();

      // power-up timing
      power_up_seq("powerup");

      // fetch enable is sticky while the switch drops in RUN
      bif.fetch_sw_i = 1'b0;
      repeat (8) tick();
      check_eq("sticky_fetch", 32'(bif.fetch_en_o), 32'd1);
      check_eq("deb_low",      32'(dut.u_debounce.sw_o), 32'd0);

      // back to a saturated WAIT_FETCH with the switch off
      bif.sw_reset_req_i = 1'b1;
      tick();
      bif.sw_reset_req_i = 1'b0;
      repeat (RH + FD + 2) tick();
      check_eq("wait_fetch_state", 32'(bif.state_o), 32'd2);

      // bouncing switch, with a status pulse that must be ignored
      toggles = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         bif.fetch_sw_i = toggles[3-i];
         bif.status_i   = (i == 1);
         tick();
         bif.status_i   = 1'b0;
         tick();
         check_eq("bounce_deb",   32'(dut.u_debounce.sw_o), 32'd0);
         check_eq("bounce_fetch", 32'(bif.fetch_en_o), 32'd0);
      end
      check_eq("wf_status_done", 32'(bif.done_o), 32'd0);

      // settle at 1: synced after edge k+1, debounced after k+4, fetch at k+5
      bif.fetch_sw_i = 1'b1;
      for (int i = 0; i <= 5; i++) begin
         tick();
         check_eq("settle_deb",   32'(dut.u_debounce.sw_o), 32'(i >= 4));
         check_eq("settle_fetch", 32'(bif.fetch_en_o),      32'(i >= 5));
      end

      // completion
      bif.status_i = 1'b1;
      tick();
      bif.status_i = 1'b0;
      check_eq("done_set",   32'(bif.done_o),  32'd1);
      check_eq("done_state", 32'(bif.state_o), 32'd4);
      repeat (5) tick();
      check_eq("done_held",  32'(bif.done_o),  32'd1);

      // reset request held 5 cycles in DONE
      bif.sw_reset_req_i = 1'b1;
      tick();
      check_eq("req_rst",   32'(bif.soc_rst_no), 32'd0);
      check_eq("req_fetch", 32'(bif.fetch_en_o), 32'd0);
      check_eq("req_done",  32'(bif.done_o),     32'd0);
      repeat (4) tick();
      bif.sw_reset_req_i = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 7) check_eq("req_release_7", 32'(bif.soc_rst_no), 32'd0);
         if (i == 8) check_eq("req_release_8", 32'(bif.soc_rst_no), 32'd1);
      end
      repeat (FD) tick();
      check_eq("rerun_state", 32'(bif.state_o), 32'd3);

      // lock loss together with a reset request in RUN
      bif.clk_locked_i   = 1'b0;
      bif.sw_reset_req_i = 1'b1;
      tick();
      bif.sw_reset_req_i = 1'b0;
      tick();
      tick();
      check_eq("lockloss_state", 32'(bif.state_o),    32'd0);
      check_eq("lockloss_rst",   32'(bif.soc_rst_no), 32'd0);
      repeat (5) tick();
      power_up_seq("relock");

      // asynchronous reset mid RST_HOLD, between clock edges
      bif.sw_reset_req_i = 1'b1;
      tick();
      bif.sw_reset_req_i = 1'b0;
      repeat (3) tick();
      check_eq("pre_async_state", 32'(bif.state_o), 32'd1);
      #7 rst_n = 1'b0;
      #1 check_reset_values("async");
      model_reset();
      @(negedge soc_clk);
      rst_n = 1'b1;

      // randomized traffic
      lock_off = 0;
      req_left = 0;
      bif.clk_locked_i = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (lock_off > 0) begin
            bif.clk_locked_i = 1'b0;
            lock_off--;
         end else begin
            bif.clk_locked_i = 1'b1;
            if ($urandom_range(0, 399) == 0) lock_off = $urandom_range(1, 6);
         end
         if (req_left > 0) begin
            bif.sw_reset_req_i = 1'b1;
            req_left--;
         end else begin
            bif.sw_reset_req_i = 1'b0;
            if ($urandom_range(0, 199) == 0) req_left = $urandom_range(1, 6);
         end
         if ($urandom_range(0, 7) == 0) bif.fetch_sw_i = ~bif.fetch_sw_i;
         bif.status_i = ($urandom_range(0, 15) == 0);
         if (c == 1500) begin
            #7 rst_n = 1'b0;
            #1 check_reset_values("rand_async");
            model_reset();
            @(negedge soc_clk);
            rst_n = 1'b1;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/croc_boot_seq.md
Name: croc_boot_seq

Overview:
FPGA-side boot and reset sequencer for the croc SoC on board targets. It waits for the clock wizard to lock, holds the SoC in reset for a fixed time, and then releases reset. After a further delay it asserts fetch enable, gated by a debounced board switch. It also latches SoC completion from status and exposes the sequencer state for LEDs and the ILA.

Parameters:
RstHoldCycles, 1024, number of soc_clk cycles SoC reset is held after lock or a reset request; must be >= 1.
FetchDelayCycles, 256, cycles between reset release and when fetch enable is allowed; must be >= 1.
DebounceCycles, 20000, consecutive stable cycles needed for the fetch switch to change (1 ms at 20 MHz); must be >= 1.
CntWidth, 16, counter width; must hold max(RstHoldCycles, FetchDelayCycles, DebounceCycles).

Ports:
soc_clk  input  1  system clock, 20 MHz from the clock wizard.
rst_n  input  1  asynchronous, active-low reset; clock soc_clk.
clk_locked_i  input  1  clock wizard locked; asynchronous, synchronised internally.
sw_reset_req_i  input  1  level reset request (VIO or button); synchronous to soc_clk.
fetch_sw_i  input  1  raw fetch-enable switch; asynchronous, synchronised and debounced.
status_i  input  1  SoC status output.
soc_rst_no  output  1  active-low reset to the SoC reset synchroniser.
fetch_en_o  output  1  fetch enable to the SoC.
done_o  output  1  sticky flag: SoC reported status.
state_o  output  3  current state encoding, for LEDs and debug.

Behaviour:
- Reset values: soc_rst_no=0, fetch_en_o=0, done_o=0, state_o=WAIT_LOCK, all counters 0. The debounced switch resets to 0.
- clk_locked_i passes through a 2-flop synchroniser, giving 2 cycles of latency ("lock_s").
- fetch_sw_i passes through a 2-flop synchroniser and then the debouncer.
  - The debounced output takes a new value only after the synced input has differed from the current output for DebounceCycles consecutive cycles.
  - Any bounce restarts the count.
- States and encodings: WAIT_LOCK=0, RST_HOLD=1, WAIT_FETCH=2, RUN=3, DONE=4. All outputs are registered.
- WAIT_LOCK:
  - soc_rst_no=0, fetch_en_o=0.
  - lock_s=1 -> RST_HOLD, counter cleared.
- RST_HOLD:
  - soc_rst_no=0.
  - The counter increments each cycle while sw_reset_req_i=0. It is cleared while sw_reset_req_i=1, so a held request keeps the SoC in reset.
  - When the counter reaches RstHoldCycles-1 -> WAIT_FETCH, and soc_rst_no=1 from that edge.
  - The SoC is therefore held in reset for exactly RstHoldCycles cycles.
- WAIT_FETCH:
  - soc_rst_no=1.
  - The counter runs up to FetchDelayCycles-1 and then saturates.
  - Once saturated and debounced switch=1 -> RUN.
  - status_i is ignored in this state.
- RUN:
  - fetch_en_o=1.
  - It stays 1 even if the switch drops, because the SoC samples fetch enable once and the team decision is that it is sticky until the next reset.
  - status_i=1 -> DONE.
- DONE:
  - fetch_en_o=1, done_o=1.
  - Stays here until lock loss, a reset request, or rst_n.
- Priority in every state except WAIT_LOCK:
  - lock_s=0 -> WAIT_LOCK; this is the highest priority.
  - Else sw_reset_req_i=1 -> RST_HOLD.
  - Either transition forces soc_rst_no=0 and fetch_en_o=0 on the same edge and clears done_o.
- Lock loss coincident with a reset request: lock loss wins.
- Reset request coincident with status_i=1 in RUN: RST_HOLD wins and done_o stays 0.
- Counters never wrap: increments are saturating, and every state entry clears the counter.
- rst_n asserted mid-operation: everything returns asynchronously to the reset values.

Decomposition:
- Package croc_boot_pkg holds:
  - boot_state_e, a 3-bit enum with the encodings above;
  - default parameter localparams.
- One sub-module: croc_debounce. It contains the 2-flop sync, a stable-count counter, and a registered output, parameterised by DebounceCycles and CntWidth. It is reused for future board buttons.
- The lock synchroniser uses the existing sync cell from the common cells library.

Test Plan:
- Power-up timing:
  - Stimulus: RstHoldCycles=8, FetchDelayCycles=4, DebounceCycles=3; fetch_sw_i=1 from t=0; clk_locked_i rises at edge 0.
  - Response: state_o=1 at edge 3; soc_rst_no rises at edge 11; fetch_en_o rises at edge 15.
- Debounce:
  - Stimulus: fetch_sw_i toggles 1,0,1,0 every 2 cycles, then is held at 1.
  - Response: the debounced output rises exactly 3 cycles after the synced input settles at 1. No fetch_en_o occurs before that.
- Completion:
  - Stimulus: status_i pulses for 1 cycle in RUN.
  - Response: done_o=1 and state_o=4 from the next edge, held thereafter. A status_i pulse in WAIT_FETCH leaves done_o=0.
- Reset request:
  - Stimulus: sw_reset_req_i held for 5 cycles in DONE.
  - Response: soc_rst_no=0, fetch_en_o=0 and done_o=0 on the next edge. soc_rst_no rises 8 cycles after the request drops.
- Lock loss:
  - Stimulus: clk_locked_i drops in RUN at the same cycle as sw_reset_req_i=1.
  - Response: state_o=0 (not 1) 3 edges later, and soc_rst_no=0. When lock returns, the full hold sequence repeats.
- Asynchronous reset:
  - Stimulus: rst_n asserted mid-RST_HOLD between clock edges.
  - Response: all outputs go to their reset values immediately, without waiting for a clock edge.
